// File: rtl/tap_controller_pkg.sv
// Shared JTAG definitions: IEEE 1149.1 TAP state encodings, state-decode bundle
// and the next-state function used by the TAP controller, IR/DR stages and benches.
package tap_controller_pkg;

  localparam int TAP_STATE_W = 4;

  typedef enum logic [TAP_STATE_W-1:0] {
    TAP_EX2DR   = 4'h0,
    TAP_EX1DR   = 4'h1,
    TAP_SHDR    = 4'h2,
    TAP_PAUSEDR = 4'h3,
    TAP_SELIR   = 4'h4,
    TAP_UPDDR   = 4'h5,
    TAP_CAPDR   = 4'h6,
    TAP_SELDR   = 4'h7,
    TAP_EX2IR   = 4'h8,
    TAP_EX1IR   = 4'h9,
    TAP_SHIR    = 4'hA,
    TAP_PAUSEIR = 4'hB,
    TAP_RTI     = 4'hC,
    TAP_UPDIR   = 4'hD,
    TAP_CAPIR   = 4'hE,
    TAP_TLR     = 4'hF
  } tap_state_e;

  typedef struct packed {
    logic test_logic_reset;
    logic run_test_idle;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
  } tap_decode_t;

  function automatic tap_state_e tap_next_state(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = TAP_TLR;
    unique case (s)
      TAP_TLR:     if (tms) n = TAP_TLR;     else n = TAP_RTI;
      TAP_RTI:     if (tms) n = TAP_SELDR;   else n = TAP_RTI;
      TAP_SELDR:   if (tms) n = TAP_SELIR;   else n = TAP_CAPDR;
      TAP_CAPDR:   if (tms) n = TAP_EX1DR;   else n = TAP_SHDR;
      TAP_SHDR:    if (tms) n = TAP_EX1DR;   else n = TAP_SHDR;
      TAP_EX1DR:   if (tms) n = TAP_UPDDR;   else n = TAP_PAUSEDR;
      TAP_PAUSEDR: if (tms) n = TAP_EX2DR;   else n = TAP_PAUSEDR;
      TAP_EX2DR:   if (tms) n = TAP_UPDDR;   else n = TAP_SHDR;
      TAP_UPDDR:   if (tms) n = TAP_SELDR;   else n = TAP_RTI;
      TAP_SELIR:   if (tms) n = TAP_TLR;     else n = TAP_CAPIR;
      TAP_CAPIR:   if (tms) n = TAP_EX1IR;   else n = TAP_SHIR;
      TAP_SHIR:    if (tms) n = TAP_EX1IR;   else n = TAP_SHIR;
      TAP_EX1IR:   if (tms) n = TAP_UPDIR;   else n = TAP_PAUSEIR;
      TAP_PAUSEIR: if (tms) n = TAP_EX2IR;   else n = TAP_PAUSEIR;
      TAP_EX2IR:   if (tms) n = TAP_UPDIR;   else n = TAP_SHIR;
      TAP_UPDIR:   if (tms) n = TAP_SELDR;   else n = TAP_RTI;
      default:     n = TAP_TLR;
    endcase
    return n;
  endfunction

  // Pure function of the state: decodes must never see TMS.
  function automatic tap_decode_t tap_decode(input tap_state_e s);
    tap_decode_t d;
    d = '0;
    unique case (s)
      TAP_TLR:   d.test_logic_reset = 1'b1;
      TAP_RTI:   d.run_test_idle    = 1'b1;
      TAP_CAPIR: d.capture_ir       = 1'b1;
      TAP_SHIR:  d.shift_ir         = 1'b1;
      TAP_UPDIR: d.update_ir        = 1'b1;
      TAP_CAPDR: d.capture_dr       = 1'b1;
      TAP_SHDR:  d.shift_dr         = 1'b1;
      TAP_UPDDR: d.update_dr        = 1'b1;
      default:   d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tap_controller_if.sv
// TAP controller signal bundle: TMS and serial-return inputs, state, decodes and TDO pad.
// master = test-access driver side, slave = the TAP controller itself.
interface tap_controller_if;
  import tap_controller_pkg::*;

  logic                   tms;
  logic                   instr_tdo;
  logic                   dr_tdo;
  logic [TAP_STATE_W-1:0] state;
  logic                   test_logic_reset;
  logic                   run_test_idle;
  logic                   capture_ir;
  logic                   shift_ir;
  logic                   update_ir;
  logic                   capture_dr;
  logic                   shift_dr;
  logic                   update_dr;
  logic                   tdo;
  logic                   tdo_en;

  modport master (
    output tms, instr_tdo, dr_tdo,
    input  state, test_logic_reset, run_test_idle,
    input  capture_ir, shift_ir, update_ir,
    input  capture_dr, shift_dr, update_dr,
    input  tdo, tdo_en
  );

  modport slave (
    input  tms, instr_tdo, dr_tdo,
    output state, test_logic_reset, run_test_idle,
    output capture_ir, shift_ir, update_ir,
    output capture_dr, shift_dr, update_dr,
    output tdo, tdo_en
  );

endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: rising-edge state machine, state decodes, and a
// falling-edge TDO enable/select stage that lines up with the IR/DR serial outputs.
module tap_controller
  import tap_controller_pkg::*;
(
  input  logic           tck_i,
  input  logic           trst_i,
  tap_controller_if.slave tap
);

  tap_state_e  state_q;
  tap_state_e  state_d;
  tap_decode_t dec;
  logic        tdo_en_q;
  logic        tdo_en_d;
  logic        ir_sel_q;
  logic        ir_sel_d;

  always_comb begin
    state_d = tap_next_state(state_q, tap.tms);
  end

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      state_q <= TAP_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  assign dec = tap_decode(state_q);

  assign tap.state            = state_q;
  assign tap.test_logic_reset = dec.test_logic_reset;
  assign tap.run_test_idle    = dec.run_test_idle;
  assign tap.capture_ir       = dec.capture_ir;
  assign tap.shift_ir         = dec.shift_ir;
  assign tap.update_ir        = dec.update_ir;
  assign tap.capture_dr       = dec.capture_dr;
  assign tap.shift_dr         = dec.shift_dr;
  assign tap.update_dr        = dec.update_dr;

  // Falling-edge stage: enable and path select trail the shift states by half a TCK.
  assign tdo_en_d = dec.shift_ir | dec.shift_dr;
  assign ir_sel_d = dec.shift_ir;

  always_ff @(negedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      tdo_en_q <= 1'b0;
      ir_sel_q <= 1'b0;
    end else begin
      tdo_en_q <= tdo_en_d;
      ir_sel_q <= ir_sel_d;
    end
  end

  assign tap.tdo_en = tdo_en_q;
  assign tap.tdo    = tdo_en_q & (ir_sel_q ? tap.instr_tdo : tap.dr_tdo);

endmodule

// File: tb/tb_tap_controller.sv
// Directed self-checking bench for tap_controller: reset, IR/DR scans, pause loop,
// TRST mid-shift, TDO path select, and the five-TMS=1 return from all 16 states.
module tb_tap_controller;

  logic tck;
  logic trst;
  logic tdi;
  int   checks;
  int   errors;

  logic [3:0] ir_sr;
  logic [3:0] ir_q;
  logic       watch_upd;
  logic       upd_seen;
  logic [7:0] dec;

  logic [7:0] walk_path [16];
  int         walk_len  [16];
  logic [3:0] walk_exp  [16];

  tap_controller_if bus ();

  tap_controller dut (
    .tck_i  (tck),
    .trst_i (trst),
    .tap    (bus)
  );

  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  assign dec = {bus.test_logic_reset, bus.run_test_idle, bus.capture_ir, bus.shift_ir,
                bus.update_ir, bus.capture_dr, bus.shift_dr, bus.update_dr};

  // Bench-side IR stage: shifts TDI LSB-first in Shift-IR, latches on falling edge in Update-IR.
  always @(posedge tck) begin
    if (bus.shift_ir) ir_sr <= {tdi, ir_sr[3:1]};
  end

  always @(negedge tck) begin
    if (bus.update_ir) ir_q <= ir_sr;
  end

  always @(posedge bus.update_ir) begin
    if (watch_upd) upd_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_tms(input logic t);
    bus.tms = t;
    @(posedge tck);
    #1;
  endtask

  task automatic at_neg();
    @(negedge tck);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    ir_sr     = 4'h0;
    ir_q      = 4'h0;
    watch_upd = 1'b0;
    upd_seen  = 1'b0;
    tdi       = 1'b0;
    trst      = 1'b1;
    bus.tms       = 1'b0;
    bus.instr_tdo = 1'b0;
    bus.dr_tdo    = 1'b0;

    walk_path[0]  = 8'b0;        walk_len[0]  = 0; walk_exp[0]  = 4'hF;
    walk_path[1]  = 8'b0;        walk_len[1]  = 1; walk_exp[1]  = 4'hC;
    walk_path[2]  = 8'b10;       walk_len[2]  = 2; walk_exp[2]  = 4'h7;
    walk_path[3]  = 8'b010;      walk_len[3]  = 3; walk_exp[3]  = 4'h6;
    walk_path[4]  = 8'b0010;     walk_len[4]  = 4; walk_exp[4]  = 4'h2;
    walk_path[5]  = 8'b1010;     walk_len[5]  = 4; walk_exp[5]  = 4'h1;
    walk_path[6]  = 8'b01010;    walk_len[6]  = 5; walk_exp[6]  = 4'h3;
    walk_path[7]  = 8'b101010;   walk_len[7]  = 6; walk_exp[7]  = 4'h0;
    walk_path[8]  = 8'b11010;    walk_len[8]  = 5; walk_exp[8]  = 4'h5;
    walk_path[9]  = 8'b110;      walk_len[9]  = 3; walk_exp[9]  = 4'h4;
    walk_path[10] = 8'b0110;     walk_len[10] = 4; walk_exp[10] = 4'hE;
    walk_path[11] = 8'b00110;    walk_len[11] = 5; walk_exp[11] = 4'hA;
    walk_path[12] = 8'b10110;    walk_len[12] = 5; walk_exp[12] = 4'h9;
    walk_path[13] = 8'b010110;   walk_len[13] = 6; walk_exp[13] = 4'hB;
    walk_path[14] = 8'b1010110;  walk_len[14] = 7; walk_exp[14] = 4'h8;
    walk_path[15] = 8'b110110;   walk_len[15] = 6; walk_exp[15] = 4'hD;

    // Reset held, clock running
    #3;
    chk("rst_state", {4'h0, bus.state}, 8'h0F);
    chk("rst_dec", dec, 8'h80);
    chk("rst_tdo_en", {7'h0, bus.tdo_en}, 8'h00);
    chk("rst_tdo", {7'h0, bus.tdo}, 8'h00);
    repeat (2) @(posedge tck);
    #1;
    chk("rst_hold_state", {4'h0, bus.state}, 8'h0F);
    @(negedge tck);
    #2 trst = 1'b0;

    clk_tms(1'b0);
    chk("rti_state", {4'h0, bus.state}, 8'h0C);
    chk("rti_dec", dec, 8'h40);

    // IR scan: 1,1,0,0 then shift 4 bits (TDI 1,1,1,0) with TMS 0,0,0,1
    clk_tms(1'b1); chk("ir_seldr", {4'h0, bus.state}, 8'h07);
    clk_tms(1'b1); chk("ir_selir", {4'h0, bus.state}, 8'h04);
    clk_tms(1'b0); chk("ir_capir", {4'h0, bus.state}, 8'h0E);
    chk("ir_capir_dec", dec, 8'h20);
    clk_tms(1'b0); chk("ir_shir", {4'h0, bus.state}, 8'h0A);
    chk("ir_shir_dec", dec, 8'h10);
    chk("ir_en_before_neg", {7'h0, bus.tdo_en}, 8'h00);
    bus.instr_tdo = 1'b1;
    bus.dr_tdo    = 1'b0;
    at_neg();
    chk("ir_en_after_neg", {7'h0, bus.tdo_en}, 8'h01);
    chk("ir_tdo_instr", {7'h0, bus.tdo}, 8'h01);
    for (int k = 0; k < 4; k++) begin
      tdi = (k < 3) ? 1'b1 : 1'b0;
      clk_tms(k == 3);
    end
    chk("ir_ex1ir", {4'h0, bus.state}, 8'h09);
    chk("ir_ex1ir_dec", dec, 8'h00);
    at_neg();
    chk("ir_en_fall", {7'h0, bus.tdo_en}, 8'h00);
    chk("ir_tdo_off", {7'h0, bus.tdo}, 8'h00);
    clk_tms(1'b1); chk("ir_updir", {4'h0, bus.state}, 8'h0D);
    chk("ir_updir_dec", dec, 8'h08);
    clk_tms(1'b0); chk("ir_back_rti", {4'h0, bus.state}, 8'h0C);
    chk("ir_upd_one_tck", dec, 8'h40);
    chk("ir_latched", {4'h0, ir_q}, 8'h07);

    // Pause loop in the IR column
    clk_tms(1'b1); clk_tms(1'b1); clk_tms(1'b0); clk_tms(1'b0);
    chk("pz_shir", {4'h0, bus.state}, 8'h0A);
    at_neg();
    chk("pz_en_shir", {7'h0, bus.tdo_en}, 8'h01);
    clk_tms(1'b1); chk("pz_ex1ir", {4'h0, bus.state}, 8'h09);
    for (int k = 0; k < 10; k++) begin
      clk_tms(1'b0);
      chk($sformatf("pz_state%0d", k), {4'h0, bus.state}, 8'h0B);
      at_neg();
      chk($sformatf("pz_dec%0d", k), dec, 8'h00);
      chk($sformatf("pz_en%0d", k), {6'h0, bus.tdo_en, bus.tdo}, 8'h00);
    end
    clk_tms(1'b1); chk("pz_ex2ir", {4'h0, bus.state}, 8'h08);
    clk_tms(1'b0); chk("pz_reshir", {4'h0, bus.state}, 8'h0A);
    at_neg();
    chk("pz_en_again", {7'h0, bus.tdo_en}, 8'h01);
    chk("pz_tdo_again", {7'h0, bus.tdo}, 8'h01);
    clk_tms(1'b1); clk_tms(1'b1); clk_tms(1'b0);
    chk("pz_exit_rti", {4'h0, bus.state}, 8'h0C);
    at_neg();
    chk("rti_tdo_en", {7'h0, bus.tdo_en}, 8'h00);
    chk("rti_tdo", {7'h0, bus.tdo}, 8'h00);

    // DR scan: 1,0,0 -> Shift-DR, TDO follows DR_TDO only
    clk_tms(1'b1); chk("dr_seldr", {4'h0, bus.state}, 8'h07);
    clk_tms(1'b0); chk("dr_capdr_dec", dec, 8'h04);
    clk_tms(1'b0); chk("dr_shdr", {4'h0, bus.state}, 8'h02);
    chk("dr_shdr_dec", dec, 8'h02);
    chk("dr_en_before_neg", {7'h0, bus.tdo_en}, 8'h00);
    at_neg();
    chk("dr_en_after_neg", {7'h0, bus.tdo_en}, 8'h01);
    chk("dr_tdo_ignores_ir", {7'h0, bus.tdo}, 8'h00);
    bus.instr_tdo = 1'b0;
    bus.dr_tdo    = 1'b1;
    #1;
    chk("dr_tdo_follows", {7'h0, bus.tdo}, 8'h01);
    clk_tms(1'b1); clk_tms(1'b1);
    chk("dr_upddr_dec", dec, 8'h01);
    clk_tms(1'b0); chk("dr_back_rti", {4'h0, bus.state}, 8'h0C);

    // TRST asserted while in Shift-IR
    bus.instr_tdo = 1'b1;
    clk_tms(1'b1); clk_tms(1'b1); clk_tms(1'b0); clk_tms(1'b0);
    chk("tr_shir", {4'h0, bus.state}, 8'h0A);
    at_neg();
    chk("tr_en_pre", {7'h0, bus.tdo_en}, 8'h01);
    watch_upd = 1'b1;
    upd_seen  = 1'b0;
    bus.tms   = 1'b1;
    #2 trst = 1'b1;
    #1;
    chk("tr_state_async", {4'h0, bus.state}, 8'h0F);
    chk("tr_dec", dec, 8'h80);
    chk("tr_en", {6'h0, bus.tdo_en, bus.tdo}, 8'h00);
    repeat (3) @(posedge tck);
    #1;
    chk("tr_hold", {4'h0, bus.state}, 8'h0F);
    @(negedge tck);
    #2 trst = 1'b0;
    bus.tms = 1'b0;
    @(posedge tck);
    #1;
    watch_upd = 1'b0;
    chk("tr_no_update", {7'h0, upd_seen}, 8'h00);
    chk("tr_first_edge_rti", {4'h0, bus.state}, 8'h0C);

    // Every state reaches TLR after five TMS=1 edges
    for (int i = 0; i < 16; i++) begin
      @(negedge tck);
      #2 trst = 1'b1;
      #1 trst = 1'b0;
      for (int b = 0; b < walk_len[i]; b++) begin
        clk_tms(walk_path[i][b]);
      end
      chk($sformatf("walk%0d_state", i), {4'h0, bus.state}, {4'h0, walk_exp[i]});
      repeat (5) clk_tms(1'b1);
      chk($sformatf("walk%0d_tlr", i), {4'h0, bus.state}, 8'h0F);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 The block SHALL have no parameters; the IEEE 1149.1 state encodings are fixed constants.
REQ-002 TCK  input  1  the only clock; the FSM uses the rising edge and the TDO stage uses the falling edge.
REQ-003 TRST  input  1  reset, asynchronous and active-high.
REQ-004 TMS  input  1  test mode select, sampled on rising TCK.
REQ-005 INSTR_TDO  input  1  IR serial output, already falling-edge registered by the IR stage.
REQ-006 DR_TDO  input  1  selected data-register serial output, falling-edge registered by its source.
REQ-007 STATE  output  4  current TAP state, registered.
REQ-008 TEST_LOGIC_RESET, RUN_TEST_IDLE  output  1 each  state decodes.
REQ-009 CAPTUREIR, SHIFTIR, UPDATEIR  output  1 each  state decodes driving the instruction register.
REQ-010 CAPTUREDR, SHIFTDR, UPDATEDR  output  1 each  state decodes driving the data registers.
REQ-011 TDO  output  1  serial test data out.
REQ-012 TDO_EN  output  1  output-buffer enable for the TDO pad.

Function
REQ-013 The FSM SHALL implement the 16 IEEE 1149.1 states with these encodings: TLR=F, RTI=C, SELDR=7, CAPDR=6, SHDR=2, EX1DR=1, PAUSEDR=3, EX2DR=0, UPDDR=5, SELIR=4, CAPIR=E, SHIR=A, EX1IR=9, PAUSEIR=B, EX2IR=8, UPDIR=D.
REQ-014 Transitions SHALL occur on rising TCK as follows (TMS=0 / TMS=1):
- TLR: RTI / TLR
- RTI: RTI / SELDR
- SELDR: CAPDR / SELIR
- SELIR: CAPIR / TLR
- CAPxR: SHxR / EX1xR
- SHxR: SHxR / EX1xR
- EX1xR: PAUSExR / UPDxR
- PAUSExR: PAUSExR / EX2xR
- EX2xR: SHxR / UPDxR
- UPDxR: RTI / SELDR
REQ-015 Each decode output SHALL be a combinational function of the STATE register only, high throughout its state and never a function of TMS.
REQ-016 From any state, five consecutive rising TCK edges with TMS=1 SHALL reach TLR.
REQ-017 On falling TCK, TDO_EN SHALL register (SHIFTIR | SHIFTDR), and a path-select flag SHALL register SHIFTIR.
REQ-018 TDO SHALL be INSTR_TDO when TDO_EN=1 and the select flag=1, DR_TDO when TDO_EN=1 and the select flag=0, and 0 when TDO_EN=0.
REQ-019 Consequence of REQ-017: TDO_EN rises half a TCK after entry into SHxR and falls half a TCK after exit, aligned with the falling-edge data from the IR and DR stages.
REQ-020 Pause states SHALL hold every output stable indefinitely while TMS=0.

Reset
REQ-021 While TRST=1, the block SHALL hold STATE=F (TLR), TEST_LOGIC_RESET=1, all other decodes=0, TDO_EN=0, select flag=0, and TDO=0, independent of TCK.
REQ-022 TRST asserted mid-shift SHALL immediately force TLR and TDO_EN=0 with no partial update pulse.
REQ-023 After TRST deasserts, the first rising TCK SHALL evaluate TMS from TLR.

Structure
REQ-024 The 16 state encodings SHALL live in a shared JTAG package, also used by the IR/DR stages and benches.
REQ-025 The block SHALL be flat: one next-state process, one state register, one decode block, and one falling-edge TDO stage, with no sub-module.

Verification
REQ-026 TRST pulse -> STATE=F and TEST_LOGIC_RESET=1; then TMS=0 for one TCK -> STATE=C and RUN_TEST_IDLE=1.
REQ-027 From RTI, TMS sequence 1,1,0,0 -> CAPIR then SHIR, with CAPTUREIR high for exactly one TCK; shift 4 bits with TMS=0,0,0,1 -> EX1IR; TMS=1 -> UPDIR with UPDATEIR high for one TCK; IR latches the shifted value 4'h7.
REQ-028 From RTI, TMS sequence 1,0,0 -> SHDR; TDO_EN rises on the next falling edge and TDO follows DR_TDO, with INSTR_TDO ignored.
REQ-029 Scenarios for the pause loop, reset path and TDO path:
- Pause loop SHIR -> EX1IR -> PAUSEIR held for 10 TCK -> EX2IR -> SHIR: outputs stable during pause, TDO_EN=0 during pause and 1 again after re-entry.
- From each of the 16 states, TMS=1 for 5 TCK -> STATE=F; TRST asserted while STATE=A -> STATE=F asynchronously, TDO_EN=0, and UPDATEIR never asserted.
- In SHIR with INSTR_TDO=1 and DR_TDO=0 -> TDO=1; in SHDR with the same inputs -> TDO=0; in RTI -> TDO=0 and TDO_EN=0.
